// File: rtl/sprite_pkg.sv
// Shared constants and types for the circle-sprite read path.
// Build option: define SPRITE_SCALE2_EN for a 32x32 footprint with 2x pixel replication.
package sprite_pkg;

    localparam int unsigned SPR_DIM  = 16;
    localparam int unsigned SPR_AW   = 9;
    localparam int unsigned COORD_W  = 9;
    localparam int unsigned SCREEN_W = 256;
    localparam int unsigned SCREEN_H = 240;

    typedef logic [2:0] color_t;
    localparam color_t TRANSPARENT = 3'b000;

`ifdef SPRITE_SCALE2_EN
    localparam int unsigned SPR_SCALE = 2;
`else
    localparam int unsigned SPR_SCALE = 1;
`endif
    // On-screen footprint edge length in pixels
    localparam int unsigned SPR_FOOT = SPR_DIM * SPR_SCALE;

endpackage

// File: rtl/sprite_anim_ctrl.sv
// Sprite position (shadow/active, committed at frame start) and animation-frame selection.
// Sub-block of sprite_reader; unaffected by SPRITE_SCALE2_EN.
module sprite_anim_ctrl
    import sprite_pkg::*;
#(
    parameter int unsigned ANIM_PERIOD = 30,
    parameter int unsigned INIT_X      = 120,
    parameter int unsigned INIT_Y      = 112
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               frame_start,
    input  logic               pos_load,
    input  logic [COORD_W-1:0] pos_x_in,
    input  logic [COORD_W-1:0] pos_y_in,
    output logic [COORD_W-1:0] act_x,
    output logic [COORD_W-1:0] act_y,
    output logic               anim_sel
);

    localparam int unsigned CNT_W = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;

    logic [COORD_W-1:0] shd_x;
    logic [COORD_W-1:0] shd_y;
    logic [CNT_W-1:0]   anim_cnt;

    // Active position only moves at frame start so a frame is never torn
    always_ff @(posedge clock) begin
        if (reset) begin
            shd_x    <= COORD_W'(INIT_X);
            shd_y    <= COORD_W'(INIT_Y);
            act_x    <= COORD_W'(INIT_X);
            act_y    <= COORD_W'(INIT_Y);
            anim_cnt <= '0;
            anim_sel <= 1'b0;
        end else begin
            if (pos_load) begin
                shd_x <= pos_x_in;
                shd_y <= pos_y_in;
            end
            if (frame_start) begin
                act_x <= pos_load ? pos_x_in : shd_x;
                act_y <= pos_load ? pos_y_in : shd_y;
                if (anim_cnt == CNT_W'(ANIM_PERIOD - 1)) begin
                    anim_cnt <= '0;
                    anim_sel <= ~anim_sel;
                end else begin
                    anim_cnt <= anim_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/sprite_reader.sv
// Sprite RAM read-side renderer: scan coordinate -> RAM address -> per-pixel colour/hit, latency 3.
// Build option: SPRITE_SCALE2_EN selects the 32x32 replicated footprint.
module sprite_reader
    import sprite_pkg::*;
#(
    parameter int unsigned ANIM_PERIOD = 30,
    parameter int unsigned INIT_X      = 120,
    parameter int unsigned INIT_Y      = 112
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [8:0]        pix_x,
    input  logic [8:0]        pix_y,
    input  logic              pix_valid,
    input  logic              frame_start,
    input  logic              pos_load,
    input  logic [8:0]        pos_x_in,
    input  logic [8:0]        pos_y_in,
    output logic              RE,
    output logic [8:0]        rAddr,
    input  logic [2:0]        ram_data,
    output logic [2:0]        pix_color,
    output logic              pix_hit,
    output logic              anim_sel
);

    logic [COORD_W-1:0] act_x;
    logic [COORD_W-1:0] act_y;
    logic [9:0]         dx_c;
    logic [9:0]         dy_c;
    logic               in_box_c;
    logic [SPR_AW-1:0]  addr_c;
    logic               v1;
    logic               v2;

    sprite_anim_ctrl #(
        .ANIM_PERIOD (ANIM_PERIOD),
        .INIT_X      (INIT_X),
        .INIT_Y      (INIT_Y)
    ) u_anim_ctrl (
        .clock       (clock),
        .reset       (reset),
        .frame_start (frame_start),
        .pos_load    (pos_load),
        .pos_x_in    (pos_x_in),
        .pos_y_in    (pos_y_in),
        .act_x       (act_x),
        .act_y       (act_y),
        .anim_sel    (anim_sel)
    );

    // 10-bit difference: bit 9 set means the scan is left of / above the sprite
    assign dx_c = {1'b0, pix_x} - {1'b0, act_x};
    assign dy_c = {1'b0, pix_y} - {1'b0, act_y};

    assign in_box_c = pix_valid
                    && ({1'b0, pix_x} < 10'(SCREEN_W)) && ({1'b0, pix_y} < 10'(SCREEN_H))
                    && !dx_c[9] && !dy_c[9]
                    && (dx_c < 10'(SPR_FOOT)) && (dy_c < 10'(SPR_FOOT));

`ifdef SPRITE_SCALE2_EN
    assign addr_c = {anim_sel, dy_c[4:1], dx_c[4:1]};
`else
    assign addr_c = {anim_sel, dy_c[3:0], dx_c[3:0]};
`endif

    // Address stage, RAM-wait stage, then colour/hit stage
    always_ff @(posedge clock) begin
        if (reset) begin
            RE        <= 1'b0;
            rAddr     <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            pix_hit   <= 1'b0;
            pix_color <= TRANSPARENT;
        end else begin
            RE <= in_box_c;
            v1 <= in_box_c;
            if (in_box_c) begin
                rAddr <= addr_c;
            end
            v2 <= v1;
            if (v2 && (ram_data != TRANSPARENT)) begin
                pix_hit   <= 1'b1;
                pix_color <= ram_data;
            end else begin
                pix_hit   <= 1'b0;
                pix_color <= TRANSPARENT;
            end
        end
    end

endmodule
